// File: rtl/charge_accum_pkg.sv
// Shared types, default widths and the saturating adder for the charge accumulator controller.
package charge_accum_pkg;

    localparam int DEFAULT_ADDR_W   = 8;
    localparam int DEFAULT_DATA_W   = 16;
    localparam int DEFAULT_WEIGHT_W = 8;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_CLR = 1'b1
    } op_t;

    typedef logic [1:0] state_t;

    localparam state_t ST_INIT  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;

    // Operands arrive already sign-extended to 32 bits; the extra sum bit means
    // the pre-clamp value can never wrap for any width up to 31.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int width);
        logic signed [32:0] sum;
        logic signed [32:0] max_v;
        logic signed [32:0] min_v;
        sum   = $signed({a[31], a}) + $signed({b[31], b});
        max_v = (33'sd1 <<< (width - 1)) - 33'sd1;
        min_v = -(33'sd1 <<< (width - 1));
        if (sum > max_v) begin
            sum = max_v;
        end else if (sum < min_v) begin
            sum = min_v;
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/charge_accum_ctrl.sv
// Read-modify-write controller for the accumulated-charge RAM: arbitration, 2-stage
// saturating update with one-deep forwarding, and a full zeroing sweep.
module charge_accum_ctrl
    import charge_accum_pkg::*;
#(
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int WEIGHT_W = DEFAULT_WEIGHT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                add_valid,
    output logic                add_ready,
    input  logic [ADDR_W-1:0]   add_addr,
    input  logic [WEIGHT_W-1:0] add_weight,
    input  logic                clr_valid,
    output logic                clr_ready,
    input  logic [ADDR_W-1:0]   clr_addr,
    output logic                clr_rsp_valid,
    output logic [DATA_W-1:0]   clr_rsp_data,
    input  logic                clear_all,
    output logic                init_busy,
    output logic                ram_rd_en,
    output logic [ADDR_W-1:0]   ram_rd_addr,
    input  logic [DATA_W-1:0]   ram_rd_data,
    output logic                ram_wr_en,
    output logic [ADDR_W-1:0]   ram_wr_addr,
    output logic [DATA_W-1:0]   ram_wr_data
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    state_t                      state;
    logic [ADDR_W-1:0]           sweep_addr;

    logic                        s1_valid;
    op_t                         s1_op;
    logic [ADDR_W-1:0]           s1_addr;
    logic signed [WEIGHT_W-1:0]  s1_weight;

    logic                        fwd_valid;
    logic [ADDR_W-1:0]           fwd_addr;
    logic signed [DATA_W-1:0]    fwd_data;

    logic                        run_active;
    logic                        accept_clr;
    logic                        accept_add;
    logic                        accept;
    logic [ADDR_W-1:0]           req_addr;
    logic signed [DATA_W-1:0]    operand;
    logic signed [31:0]          sat_full;
    logic signed [DATA_W-1:0]    s1_result;
    logic                        s1_write;
    logic                        init_write;
    logic                        unused_sat_hi;

    // Every output is qualified by reset so nothing leaks out while reset is held.
    assign run_active = reset && (state == ST_RUN);
    assign clr_ready  = run_active;
    assign add_ready  = run_active && !clr_valid;
    assign accept_clr = clr_valid && clr_ready;
    assign accept_add = add_valid && add_ready;
    assign accept     = accept_clr || accept_add;
    assign req_addr   = accept_clr ? clr_addr : add_addr;

    assign ram_rd_en   = accept;
    assign ram_rd_addr = accept ? req_addr : '0;

    // The RAM reads old data when the same address is written in that cycle,
    // so the previous stage-1 result must be forwarded.
    assign operand       = (fwd_valid && (fwd_addr == s1_addr)) ? fwd_data : $signed(ram_rd_data);
    assign sat_full      = sat_add(32'(operand), 32'(s1_weight), DATA_W);
    assign unused_sat_hi = ^sat_full[31:DATA_W];
    assign s1_result     = (s1_op == OP_CLR) ? '0 : sat_full[DATA_W-1:0];

    assign s1_write   = reset && s1_valid;
    assign init_write = reset && (state == ST_INIT);
    assign init_busy  = !reset || (state == ST_INIT);

    assign clr_rsp_valid = s1_write && (s1_op == OP_CLR);
    assign clr_rsp_data  = clr_rsp_valid ? operand : '0;

    always_comb begin
        ram_wr_en   = 1'b0;
        ram_wr_addr = '0;
        ram_wr_data = '0;
        if (init_write) begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = sweep_addr;
        end else if (s1_write) begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = s1_addr;
            ram_wr_data = s1_result;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_INIT;
            sweep_addr <= '0;
            s1_valid   <= 1'b0;
            s1_op      <= OP_ADD;
            s1_addr    <= '0;
            s1_weight  <= '0;
            fwd_valid  <= 1'b0;
            fwd_addr   <= '0;
            fwd_data   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_op     <= accept_clr ? OP_CLR : OP_ADD;
                s1_addr   <= req_addr;
                s1_weight <= accept_clr ? '0 : $signed(add_weight);
            end
            fwd_valid <= s1_valid;
            if (s1_valid) begin
                fwd_addr <= s1_addr;
                fwd_data <= s1_result;
            end
            // DRAIN waits for the last in-flight write before the sweep restarts.
            case (state)
                ST_INIT: begin
                    if (sweep_addr == LAST_ADDR) begin
                        state <= ST_RUN;
                    end else begin
                        sweep_addr <= sweep_addr + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (clear_all) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!s1_valid) begin
                        state      <= ST_INIT;
                        sweep_addr <= '0;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_charge_accum_ctrl.sv
// Self-checking bench for charge_accum_ctrl with a read-first RAM model and a
// request-level reference model of the charge memory.
module tb_charge_accum_ctrl;

    logic               clk;
    logic               reset;
    logic               add_valid;
    logic               add_ready;
    logic [7:0]         add_addr;
    logic signed [7:0]  add_weight;
    logic               clr_valid;
    logic               clr_ready;
    logic [7:0]         clr_addr;
    logic               clr_rsp_valid;
    logic [15:0]        clr_rsp_data;
    logic               clear_all;
    logic               init_busy;
    logic               ram_rd_en;
    logic [7:0]         ram_rd_addr;
    logic [15:0]        ram_rd_data;
    logic               ram_wr_en;
    logic [7:0]         ram_wr_addr;
    logic [15:0]        ram_wr_data;

    logic [15:0]        ram [256];
    int                 model_mem [256];
    logic signed [15:0] rsp_q [$];
    logic signed [15:0] exp_q [$];
    int                 n_cmp;
    int                 n_fail;

    charge_accum_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .add_valid     (add_valid),
        .add_ready     (add_ready),
        .add_addr      (add_addr),
        .add_weight    (add_weight),
        .clr_valid     (clr_valid),
        .clr_ready     (clr_ready),
        .clr_addr      (clr_addr),
        .clr_rsp_valid (clr_rsp_valid),
        .clr_rsp_data  (clr_rsp_data),
        .clear_all     (clear_all),
        .init_busy     (init_busy),
        .ram_rd_en     (ram_rd_en),
        .ram_rd_addr   (ram_rd_addr),
        .ram_rd_data   (ram_rd_data),
        .ram_wr_en     (ram_wr_en),
        .ram_wr_addr   (ram_wr_addr),
        .ram_wr_data   (ram_wr_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (ram_rd_en === 1'b1) ram_rd_data <= ram[ram_rd_addr];
        if (ram_wr_en === 1'b1) ram[ram_wr_addr] <= ram_wr_data;
    end

    always @(negedge clk) begin
        if (clr_rsp_valid === 1'b1) rsp_q.push_back($signed(clr_rsp_data));
    end

    function automatic int model_sat(input int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    function automatic void model_zero_all();
        for (int i = 0; i < 256; i++) model_mem[i] = 0;
    endfunction

    // Drives one cycle of requests and applies them to the model in acceptance order.
    task automatic issue(input logic cv, input logic [7:0] ca,
                         input logic av, input logic [7:0] aa, input logic signed [7:0] aw);
        clr_valid  = cv;
        clr_addr   = ca;
        add_valid  = av;
        add_addr   = aa;
        add_weight = aw;
        if (cv) begin
            exp_q.push_back(16'(model_mem[ca]));
            model_mem[ca] = 0;
        end else if (av) begin
            model_mem[aa] = model_sat(model_mem[aa] + int'(aw));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        clr_valid = 1'b0;
        add_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Counts init_busy cycles of one sweep and the writes that stray from 0..255 with data 0.
    task automatic measure_sweep(input int pulse_at, output int cycles, output int bad,
                                 output logic rdy_after);
        cycles    = 0;
        bad       = 0;
        rdy_after = 1'b0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            clear_all = (cycles == pulse_at);
            if (init_busy === 1'b1) begin
                if (!(ram_wr_en === 1'b1 && ram_wr_addr === 8'(cycles) && ram_wr_data === 16'h0)) bad++;
                cycles++;
            end else if (cycles > 0) begin
                rdy_after = clr_ready;
                break;
            end
        end
        clear_all = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int   cycles;
        int   bad;
        logic rdy;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({add_ready, clr_ready, clr_rsp_valid, ram_rd_en, ram_wr_en, init_busy} !== 6'b000001) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: got %b expected 000001",
                     {add_ready, clr_ready, clr_rsp_valid, ram_rd_en, ram_wr_en, init_busy});
        end
        n_cmp++;
        if ({ram_rd_addr, ram_wr_addr, ram_wr_data, clr_rsp_data} !== 48'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_busses: got %h expected 0",
                     {ram_rd_addr, ram_wr_addr, ram_wr_data, clr_rsp_data});
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        measure_sweep(-1, cycles, bad, rdy);
        model_zero_all();
        n_cmp++;
        if (cycles !== 256) begin
            n_fail++;
            $display("[TB] FAIL init_length: got %0d cycles expected 256", cycles);
        end
        n_cmp++;
        if (bad !== 0) begin
            n_fail++;
            $display("[TB] FAIL init_writes: got %0d bad writes expected 0", bad);
        end
        n_cmp++;
        if (rdy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL init_ready: got clr_ready=%b expected 1 on cycle 257", rdy);
        end
        bad = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== 16'h0) bad++;
        n_cmp++;
        if (bad !== 0) begin
            n_fail++;
            $display("[TB] FAIL init_contents: got %0d nonzero words expected 0", bad);
        end
    endtask

    task automatic test_add_chain();
        repeat (3) issue(1'b0, 8'd0, 1'b1, 8'd5, 8'sd100);
        issue(1'b1, 8'd5, 1'b0, 8'd0, 8'sd0);
        issue(1'b1, 8'd5, 1'b0, 8'd0, 8'sd0);
        idle(3);
        n_cmp++;
        if (rsp_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("[TB] FAIL add_chain_count: got %0d responses expected %0d", rsp_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_cmp++;
                if (rsp_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("[TB] FAIL add_chain_rsp[%0d]: got %0d expected %0d", i, rsp_q[i], exp_q[i]);
                end
            end
        end
        rsp_q.delete();
        exp_q.delete();
    endtask

    task automatic test_saturation();
        repeat (300) issue(1'b0, 8'd0, 1'b1, 8'd7, 8'sd127);
        issue(1'b1, 8'd7, 1'b0, 8'd0, 8'sd0);
        repeat (300) issue(1'b0, 8'd0, 1'b1, 8'd8, -8'sd128);
        issue(1'b1, 8'd8, 1'b0, 8'd0, 8'sd0);
        idle(3);
        n_cmp++;
        if (rsp_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("[TB] FAIL sat_count: got %0d responses expected %0d", rsp_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_cmp++;
                if (rsp_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("[TB] FAIL sat_rsp[%0d]: got %0d expected %0d", i, rsp_q[i], exp_q[i]);
                end
            end
        end
        rsp_q.delete();
        exp_q.delete();
    endtask

    task automatic test_simultaneous();
        clr_valid  = 1'b1;
        clr_addr   = 8'd3;
        add_valid  = 1'b1;
        add_addr   = 8'd3;
        add_weight = 8'sd10;
        exp_q.push_back(16'(model_mem[3]));
        model_mem[3] = 0;
        @(negedge clk);
        n_cmp++;
        if ({clr_ready, add_ready} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL arb_both: got clr_ready/add_ready=%b expected 10", {clr_ready, add_ready});
        end
        @(posedge clk);
        #1;
        clr_valid = 1'b0;
        model_mem[3] = model_sat(model_mem[3] + 10);
        @(negedge clk);
        n_cmp++;
        if (add_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL arb_add_follows: got add_ready=%b expected 1", add_ready);
        end
        @(posedge clk);
        #1;
        issue(1'b1, 8'd3, 1'b0, 8'd0, 8'sd0);
        idle(3);
        n_cmp++;
        if (rsp_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("[TB] FAIL arb_count: got %0d responses expected %0d", rsp_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_cmp++;
                if (rsp_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("[TB] FAIL arb_rsp[%0d]: got %0d expected %0d", i, rsp_q[i], exp_q[i]);
                end
            end
        end
        rsp_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int bad;
        for (int i = 0; i < 400; i++) begin
            issue($urandom_range(0, 3) == 0, 8'($urandom_range(20, 23)),
                  $urandom_range(0, 1) == 1, 8'($urandom_range(20, 23)),
                  8'($urandom_range(0, 255)));
        end
        for (int a = 20; a < 24; a++) issue(1'b1, 8'(a), 1'b0, 8'd0, 8'sd0);
        idle(3);
        n_cmp++;
        if (rsp_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("[TB] FAIL b2b_count: got %0d responses expected %0d", rsp_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_cmp++;
                if (rsp_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_rsp[%0d]: got %0d expected %0d", i, rsp_q[i], exp_q[i]);
                end
            end
        end
        rsp_q.delete();
        exp_q.delete();
        bad = 0;
        for (int i = 0; i < 256; i++) if ($signed(ram[i]) !== 16'(model_mem[i])) bad++;
        n_cmp++;
        if (bad !== 0) begin
            n_fail++;
            $display("[TB] FAIL b2b_ram_image: got %0d differing words expected 0", bad);
        end
    endtask

    task automatic test_clear_all();
        int   cycles;
        int   bad;
        logic rdy;
        int   exp_wr;
        issue(1'b0, 8'd0, 1'b1, 8'd9, 8'sd50);
        exp_wr    = model_mem[9];
        add_valid = 1'b0;
        clear_all = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({ram_wr_en, ram_wr_addr, ram_wr_data} !== {1'b1, 8'd9, 16'(exp_wr)}) begin
            n_fail++;
            $display("[TB] FAIL drain_write: got en=%b addr=%0d data=%0d expected en=1 addr=9 data=%0d",
                     ram_wr_en, ram_wr_addr, $signed(ram_wr_data), exp_wr);
        end
        @(posedge clk);
        #1;
        clear_all = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({clr_ready, add_ready} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL drain_blocks: got readies=%b expected 00", {clr_ready, add_ready});
        end
        measure_sweep(50, cycles, bad, rdy);
        model_zero_all();
        n_cmp++;
        if (cycles !== 256 || bad !== 0) begin
            n_fail++;
            $display("[TB] FAIL clear_all_sweep: got %0d cycles / %0d bad expected 256 / 0", cycles, bad);
        end
        issue(1'b1, 8'd9, 1'b0, 8'd0, 8'sd0);
        idle(3);
        n_cmp++;
        if (rsp_q.size() !== 1 || exp_q.size() !== 1) begin
            n_fail++;
            $display("[TB] FAIL clear_all_count: got %0d responses expected 1", rsp_q.size());
        end else if (rsp_q[0] !== exp_q[0]) begin
            n_fail++;
            $display("[TB] FAIL clear_all_rsp: got %0d expected %0d", rsp_q[0], exp_q[0]);
        end
        rsp_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_midsweep();
        int   cycles;
        int   bad;
        logic rdy;
        logic found;
        found = 1'b0;
        clear_all = 1'b1;
        @(posedge clk);
        #1;
        clear_all = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (init_busy === 1'b1 && ram_wr_en === 1'b1 && ram_wr_addr === 8'd100) found = 1'b1;
        end
        n_cmp++;
        if (found !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL midsweep_reach: got found=%b expected 1", found);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (ram_wr_en !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL midsweep_wr_gated: got %b expected 0", ram_wr_en);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        measure_sweep(-1, cycles, bad, rdy);
        n_cmp++;
        if (cycles !== 256 || bad !== 0 || rdy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL midsweep_restart: got %0d cycles / %0d bad / rdy %b expected 256 / 0 / 1",
                     cycles, bad, rdy);
        end
        issue(1'b0, 8'd0, 1'b1, 8'd11, 8'sd20);
        add_valid = 1'b0;
        reset     = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({ram_wr_en, clr_rsp_valid} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL s1_discard: got wr_en/rsp_valid=%b expected 00", {ram_wr_en, clr_rsp_valid});
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        measure_sweep(-1, cycles, bad, rdy);
        model_zero_all();
        issue(1'b1, 8'd11, 1'b0, 8'd0, 8'sd0);
        idle(3);
        n_cmp++;
        if (rsp_q.size() !== 1 || exp_q.size() !== 1) begin
            n_fail++;
            $display("[TB] FAIL s1_discard_count: got %0d responses expected 1", rsp_q.size());
        end else if (rsp_q[0] !== exp_q[0]) begin
            n_fail++;
            $display("[TB] FAIL s1_discard_rsp: got %0d expected %0d", rsp_q[0], exp_q[0]);
        end
        rsp_q.delete();
        exp_q.delete();
    endtask

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        reset      = 1'b0;
        add_valid  = 1'b0;
        add_addr   = 8'd0;
        add_weight = 8'sd0;
        clr_valid  = 1'b0;
        clr_addr   = 8'd0;
        clear_all  = 1'b0;
        for (int i = 0; i < 256; i++) ram[i] = 16'($urandom);
        test_reset();
        test_add_chain();
        test_saturation();
        test_simultaneous();
        test_back_to_back();
        test_clear_all();
        test_reset_midsweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/charge_accum_ctrl.md
# charge_accum_ctrl

Read-modify-write controller for the 16x256 accumulated-charge dual-port RAM. Two requesters share it: synapse charge-add requests and neuron read-and-clear requests used for fire evaluation. The block arbitrates between them, sequences a 2-stage pipeline (RAM read, then saturating update and write), and forwards same-address back-to-back results. It also zeroes the whole RAM after reset or on command. It sits between the synapse/neuron processing logic and an external dp_ram_16x256 instance.

## Interface
- ADDR_W, 8, charge RAM address width (depth 2^ADDR_W)
- DATA_W, 16, signed charge width
- WEIGHT_W, 8, signed weight width; sign-extended to DATA_W before the add
- clk  in  1  clock, all logic rising-edge
- reset  in  1  synchronous, active-low (reset==0 resets)
- add_valid  in  1  charge-add request valid
- add_ready  out  1  add request accepted when add_valid & add_ready
- add_addr  in  ADDR_W  neuron index
- add_weight  in  WEIGHT_W  signed weight
- clr_valid  in  1  read-and-clear request valid
- clr_ready  out  1  clear request accepted when clr_valid & clr_ready
- clr_addr  in  ADDR_W  neuron index
- clr_rsp_valid  out  1  one-cycle pulse; no backpressure
- clr_rsp_data  out  DATA_W  charge value before the clear
- clear_all  in  1  pulse; starts a full zeroing sweep
- init_busy  out  1  sweep in progress
- ram_rd_en / ram_rd_addr  out  1 / ADDR_W  RAM read port
- ram_rd_data  in  DATA_W  registered RAM read data, valid the cycle after ram_rd_en
- ram_wr_en / ram_wr_addr / ram_wr_data  out  1 / ADDR_W / DATA_W  RAM write port

## Operation
- FSM states: INIT, RUN, DRAIN.
- INIT (entered on reset):
  - Sweeps addresses 0..2^ADDR_W-1, one write of 0 per cycle.
  - init_busy=1; add_ready=clr_ready=0.
  - After writing the last address, goes to RUN.
- RUN:
  - Arbitration is fixed priority: clr over add.
  - clr_ready=1; add_ready = ~clr_valid.
  - At most one request is accepted per cycle.
- clear_all in RUN:
  - Goes to DRAIN and blocks new acceptances.
  - When stage 1 is empty, goes to INIT starting at address 0.
  - clear_all during INIT or DRAIN is ignored.
- Stage 0 (accept cycle): ram_rd_en=1, ram_rd_addr=request addr. The op, addr and weight are latched into stage 1.
- Stage 1 (next cycle), operand selection:
  - operand = fwd_data if the stage-1 addr equals the address written by the previous cycle's stage 1 and that write was valid.
  - Otherwise operand = ram_rd_data.
- Stage 1, add: writes sat(operand + sext(weight)).
  - Result is clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1], i.e. [-32768, 32767] at the defaults.
  - The sum is computed at DATA_W+1 bits before clamping.
- Stage 1, clr: writes 0, asserts clr_rsp_valid, and sets clr_rsp_data=operand.
- Forwarding is one entry deep. It is sufficient because the RAM reads before it writes and the read-to-write distance is exactly 1 cycle.

## Timing
- Throughput: 1 request/cycle sustained.
- Request-to-write latency: 1 cycle after acceptance.
- clr_rsp_valid: asserted the cycle after acceptance.
- Reset values:
  - add_ready=0, clr_ready=0, clr_rsp_valid=0, clr_rsp_data=0.
  - init_busy=1, sweep address=0.
  - ram_rd_en=0, ram_wr_en=0, ram_rd_addr=0, ram_wr_addr=0, ram_wr_data=0.
  - Stage-1 valid=0, forward-valid=0.
- A reset asserted mid-sweep or mid-pipeline discards stage 1 (no write issues) and restarts INIT at address 0.
- INIT duration: exactly 2^ADDR_W cycles, so init_busy falls after 256 cycles at the defaults. Readies assert in the first RUN cycle.
- Simultaneous clr_valid and add_valid: clr is accepted; the add waits with add_ready=0.
- Same-address requests on consecutive cycles always see the prior result. This holds for add→add, add→clr and clr→add.
- Address wrap: the sweep counter stops at the last address. It does not wrap.

## Structure
- Package charge_accum_pkg holds:
  - the op enum (OP_ADD, OP_CLR);
  - the FSM state enum;
  - ADDR_W/DATA_W/WEIGHT_W defaults;
  - the sat_add function.
- No sub-module: the saturating adder is a package function, and the RAM is instantiated by the parent next to this controller.

## Test plan
- Reset held 3 cycles, then released → init_busy high for exactly 256 cycles, with ram_wr_addr 0..255 and data 0; readies assert on cycle 257.
- add(5,+100) three consecutive cycles, then clr(5) → clr_rsp_data=300; a following clr(5) returns 0.
- add(7,+127) ×300 back-to-back → saturates; clr(7) returns 32767. add(8,-128) ×300 → clr(8) returns -32768.
- clr_valid and add_valid together on addr 3 with weight 10 → clr accepted first and returns 0; the add then follows, and a later clr returns 10.
- clear_all with add(9) in stage 1 → that write completes, then a 256-cycle sweep runs; clr(9) afterward returns 0.
- reset asserted at sweep address 100 → the sweep restarts at 0, and no stage-1 write occurs during reset.
